coin_credit_tracker: RTL and testbench
======================================

# coin_credit_tracker

Sequential credit and timeout stage directly upstream of `calculate_current_state`. It accumulates inserted coin value into the running credit (`o_input_total`) and debits the price of each dispensed item. It runs the inactivity countdown (`o_wait_time`). On timeout or an explicit return request, it pays the remaining credit back one coin per cycle, largest denomination first.

## Interface
- `kNumCoins`, default 3: coin types; bit 0 = 100, bit 1 = 500, bit 2 = 1000.
- `kNumItems`, default 4: item types; bit 0..3 prices = 400, 500, 1000, 2000.
- `kTotalBits`, default 31: credit register width.
- `kWaitTime`, default 10: countdown reload value in cycles, must be ≥ 1.
- `COIN_VALUES`, default {32'd1000, 32'd500, 32'd100}: packed, 32 bits per coin, index 0 in the LSBs.
- `ITEM_PRICES`, default {32'd2000, 32'd1000, 32'd500, 32'd400}: packed, 32 bits per item, index 0 in the LSBs.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `i_input_coin`  in  kNumCoins  coin inserted this cycle; at most one bit set.
- `i_select_item`  in  kNumItems  selection pulse; used only to reload the countdown.
- `i_output_item`  in  kNumItems  item dispensed this cycle, from the downstream stage; at most one bit set.
- `i_trigger_return`  in  1  user return request.
- `o_input_total`  out  kTotalBits  current credit, registered.
- `o_wait_time`  out  32  remaining countdown, registered.
- `o_return_coin`  out  kNumCoins  one-hot coin paid out this cycle, registered.
- `o_returning`  out  1  high while in RETURN state.

## Operation
- States are IDLE, ACTIVE and RETURN. Reset enters IDLE.
- Every output resets to 0.
- **IDLE**
  - Credit is 0, wait is 0.
  - A nonzero `i_input_coin` credits the coin value, loads wait = kWaitTime and moves to ACTIVE.
  - Other inputs are ignored.
- **ACTIVE**, each cycle:
  - Coin: credit += value.
  - Dispense: credit -= price. The debit is applied only if credit plus any same-cycle coin is ≥ price; otherwise the dispense is ignored.
  - Coin and dispense in the same cycle: the net of both is applied in one update.
  - Any coin, any applied dispense, or any nonzero `i_select_item` reloads wait = kWaitTime.
  - Otherwise wait decrements by 1.
  - If wait == 1 with no reloading event, the next state is wait = 0 and RETURN.
  - `i_trigger_return` has priority over the countdown: it goes to RETURN with wait = 0. A coin or dispense in that same cycle is still applied to credit.
- **Overflow:** a coin whose addition would exceed 2^kTotalBits − 1 is not credited. Credit is unchanged and the countdown is still reloaded.
- **RETURN**, each cycle:
  - If credit ≥ the smallest coin value: select the largest coin value ≤ credit, register its one-hot on `o_return_coin`, and subtract that value.
  - Otherwise: `o_return_coin` = 0, credit = 0 (any remainder is discarded), move to IDLE.
  - Coin, select, dispense and trigger inputs are ignored in RETURN.
- `o_returning` = (state == RETURN), registered with the state.
- All arithmetic is unsigned. Coin values and prices are truncated to kTotalBits.

## Timing
- A coin sampled at edge N appears in `o_input_total` after edge N; latency is 1 cycle.
- Dispense debit latency is 1 cycle, so the downstream stage sees the reduced credit on the next cycle.
- Countdown from a final event at edge N:
  - `o_wait_time` = kWaitTime after edge N, then decrements by 1 per edge.
  - The value 1 is followed by 0 and `o_returning` = 1 after edge N + kWaitTime.
- Return payout with credit C:
  - One coin per cycle, starting on the edge after RETURN is entered.
  - The last coin pulse is followed by one cycle with `o_return_coin` = 0 and `o_returning` still 1.
  - The machine then returns to IDLE.
- RETURN entered with credit 0 takes exactly one cycle, with no coin pulse.
- `reset` asserted in any state clears all outputs asynchronously, without waiting for an edge. Operation resumes in IDLE on the first edge after deassertion.

## Test plan
- Reset, then `i_input_coin` = 3'b100 for one cycle:
  - Next cycle: `o_input_total` = 1000, `o_wait_time` = 10.
  - Then 9, 8, … on following cycles.
- Insert 500, then 100, then pulse `i_output_item` = 4'b0001:
  - Totals 500 → 600 → 200.
  - `o_wait_time` reloads to 10 after each event.
- With credit 1600, pulse `i_trigger_return`:
  - `o_return_coin` = 100b, 010b, 001b on three consecutive cycles (1000, 500, 100).
  - Then 000 with `o_returning` = 1, then IDLE with total 0.
- Insert one 100 coin and apply no further stimulus:
  - `o_wait_time` counts 10 → 0.
  - RETURN is entered, one 001b pulse follows, then IDLE.
- With credit 1500, pulse `i_output_item` = 4'b1000 (price 2000):
  - Credit stays 1500.
  - Same cycle coin 500 plus dispense 2000 from credit 1500: credit becomes 0.
- Assert `reset` between the 1000 and 500 pulses of a return:
  - All outputs drop to 0 immediately.
  - After deassert, a 100 coin gives total 100.

Source files
------------

// File: rtl/coin_credit_tracker.sv
// Credit accumulator, inactivity countdown and greedy coin payout for the vending path.
// Sits upstream of the dispense decision; all outputs are registered.
`timescale 1ns/1ps
module coin_credit_tracker #(
    parameter int                      kNumCoins   = 3,
    parameter int                      kNumItems   = 4,
    parameter int                      kTotalBits  = 31,
    parameter int                      kWaitTime   = 10,
    parameter logic [kNumCoins*32-1:0] COIN_VALUES = {32'd1000, 32'd500, 32'd100},
    parameter logic [kNumItems*32-1:0] ITEM_PRICES = {32'd2000, 32'd1000, 32'd500, 32'd400}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic [kNumItems-1:0]  i_output_item,
    input  logic                  i_trigger_return,
    output logic [kTotalBits-1:0] o_input_total,
    output logic [31:0]           o_wait_time,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_returning
);

    localparam logic [31:0] kWaitLoad = 32'(kWaitTime);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETURN} state_t;

    typedef struct packed {
        state_t                  st;
        logic [kTotalBits-1:0]   credit;
        logic [31:0]             wait_cnt;
        logic [kNumCoins-1:0]    ret_coin;
    } trk_t;

    function automatic logic [kTotalBits-1:0] coin_value(input int idx);
        logic [31:0] raw;
        raw = COIN_VALUES[idx*32 +: 32];
        return kTotalBits'(raw);
    endfunction

    function automatic logic [kTotalBits-1:0] item_price_of(input int idx);
        logic [31:0] raw;
        raw = ITEM_PRICES[idx*32 +: 32];
        return kTotalBits'(raw);
    endfunction

    trk_t cur, nxt;

    logic [kTotalBits-1:0] coin_val, item_price, avail, pay_val;
    logic [kTotalBits:0]   coin_sum;
    logic [kNumCoins-1:0]  pay_onehot;
    logic                  coin_fits, disp_ok, reload, pay_found;

    always_comb begin
        coin_val   = '0;
        item_price = '0;
        for (int i = 0; i < kNumCoins; i++)
            if (i_input_coin[i]) coin_val = coin_val | coin_value(i);
        for (int i = 0; i < kNumItems; i++)
            if (i_output_item[i]) item_price = item_price | item_price_of(i);
    end

    // The extra carry bit detects a coin that would wrap the credit register.
    assign coin_sum  = {1'b0, cur.credit} + {1'b0, coin_val};
    assign coin_fits = ~coin_sum[kTotalBits];
    assign avail     = coin_fits ? coin_sum[kTotalBits-1:0] : cur.credit;
    assign disp_ok   = (|i_output_item) && (avail >= item_price);
    assign reload    = (|i_input_coin) || (|i_select_item) || disp_ok;

    // Largest nonzero denomination that still fits in the remaining credit.
    always_comb begin
        pay_found  = 1'b0;
        pay_val    = '0;
        pay_onehot = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coin_value(i) != '0 && coin_value(i) <= cur.credit &&
                (!pay_found || coin_value(i) > pay_val)) begin
                pay_found     = 1'b1;
                pay_val       = coin_value(i);
                pay_onehot    = '0;
                pay_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        nxt          = cur;
        nxt.ret_coin = '0;
        case (cur.st)
            S_IDLE: begin
                nxt.credit   = '0;
                nxt.wait_cnt = '0;
                if (|i_input_coin) begin
                    nxt.st       = S_ACTIVE;
                    nxt.credit   = coin_val;
                    nxt.wait_cnt = kWaitLoad;
                end
            end
            S_ACTIVE: begin
                nxt.credit = avail - (disp_ok ? item_price : '0);
                if (i_trigger_return) begin
                    nxt.st       = S_RETURN;
                    nxt.wait_cnt = '0;
                end else if (reload) begin
                    nxt.wait_cnt = kWaitLoad;
                end else if (cur.wait_cnt <= 32'd1) begin
                    nxt.st       = S_RETURN;
                    nxt.wait_cnt = '0;
                end else begin
                    nxt.wait_cnt = cur.wait_cnt - 32'd1;
                end
            end
            S_RETURN: begin
                nxt.wait_cnt = '0;
                if (pay_found) begin
                    nxt.ret_coin = pay_onehot;
                    nxt.credit   = cur.credit - pay_val;
                end else begin
                    // After a payout, hold one quiet cycle before leaving.
                    nxt.credit = '0;
                    if (cur.ret_coin == '0) nxt.st = S_IDLE;
                end
            end
            default: begin
                nxt.st       = S_IDLE;
                nxt.credit   = '0;
                nxt.wait_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur.st       <= S_IDLE;
            cur.credit   <= '0;
            cur.wait_cnt <= '0;
            cur.ret_coin <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign o_input_total = cur.credit;
    assign o_wait_time   = cur.wait_cnt;
    assign o_return_coin = cur.ret_coin;
    assign o_returning   = (cur.st == S_RETURN);

endmodule

// File: tb/tb_coin_credit_tracker.sv
// Directed plus random checks of coin_credit_tracker against a transaction-level credit model.
`timescale 1ns/1ps
module tb_coin_credit_tracker;

    localparam int      TB = 11;
    localparam longint  MAXC = 2047;
    localparam longint  K = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  i_input_coin = '0;
    logic [3:0]  i_select_item = '0;
    logic [3:0]  i_output_item = '0;
    logic        i_trigger_return = 1'b0;
    logic [TB-1:0] o_input_total;
    logic [31:0] o_wait_time;
    logic [2:0]  o_return_coin;
    logic        o_returning;

    coin_credit_tracker #(.kTotalBits(TB)) dut (
        .clk(clk), .reset(reset),
        .i_input_coin(i_input_coin), .i_select_item(i_select_item),
        .i_output_item(i_output_item), .i_trigger_return(i_trigger_return),
        .o_input_total(o_input_total), .o_wait_time(o_wait_time),
        .o_return_coin(o_return_coin), .o_returning(o_returning)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    longint cval [3] = '{100, 500, 1000};
    longint price[4] = '{400, 500, 1000, 2000};

    // model: 0 idle, 1 active, 2 return; payout is precomputed as a queue on entry
    longint     m_credit, m_wait;
    int         m_mode;
    logic [2:0] m_ret;
    logic [2:0] m_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_wait = 0; m_mode = 0; m_ret = '0; m_q.delete();
    endtask

    task automatic build_payout();
        longint rem;
        int best;
        m_q.delete();
        rem = m_credit;
        forever begin
            best = -1;
            for (int i = 0; i < 3; i++) if (cval[i] <= rem) best = i;
            if (best < 0) break;
            m_q.push_back(3'b001 << best);
            rem -= cval[best];
        end
        if (m_q.size() > 0) m_q.push_back(3'b000);
    endtask

    function automatic longint coin_of(input logic [2:0] oh);
        longint v = 0;
        for (int i = 0; i < 3; i++) if (oh[i]) v = cval[i];
        return v;
    endfunction

    task automatic model_step(input logic [2:0] c, input logic [3:0] s,
                              input logic [3:0] it, input logic tr);
        longint add, avail;
        bit reload;
        int ii;
        ii = -1;
        for (int i = 0; i < 4; i++) if (it[i]) ii = i;
        m_ret = '0;
        case (m_mode)
            0: if (c != 0) begin
                m_credit = coin_of(c); m_wait = K; m_mode = 1;
            end
            1: begin
                add = coin_of(c);
                reload = (c != 0) || (s != 0);
                if (m_credit + add > MAXC) add = 0;
                avail = m_credit + add;
                if (ii >= 0 && avail >= price[ii]) begin
                    avail -= price[ii];
                    reload = 1;
                end
                m_credit = avail;
                if (tr) begin
                    m_mode = 2; m_wait = 0; build_payout();
                end else if (reload) begin
                    m_wait = K;
                end else if (m_wait <= 1) begin
                    m_mode = 2; m_wait = 0; build_payout();
                end else begin
                    m_wait--;
                end
            end
            default: begin
                if (m_q.size() > 0) begin
                    m_ret = m_q.pop_front();
                    if (m_ret == 0) m_credit = 0;
                    else m_credit -= coin_of(m_ret);
                end else begin
                    m_credit = 0; m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_total"}, 64'(o_input_total), 64'(m_credit));
        chk({tag, "_wait"},  64'(o_wait_time),   64'(m_wait));
        chk({tag, "_ret"},   64'(o_return_coin), 64'(m_ret));
        chk({tag, "_rtn"},   64'(o_returning),   64'(m_mode == 2));
    endtask

    task automatic cyc(input logic [2:0] c, input logic [3:0] s, input logic [3:0] it,
                       input logic tr, input string tag);
        i_input_coin = c; i_select_item = s; i_output_item = it; i_trigger_return = tr;
        @(posedge clk);
        model_step(c, s, it, tr);
        #1;
        cmp_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && m_mode != 0; k++) cyc(3'b0, 4'b0, 4'b0, m_mode == 1, tag);
        chk({tag, "_idle"}, 64'(o_returning), 64'(0));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_model("reset");
        @(negedge clk) reset = 1'b0;

        // single coin then countdown
        cyc(3'b100, 0, 0, 0, "c1000");
        chk("c1000_total_k", 64'(o_input_total), 64'd1000);
        chk("c1000_wait_k",  64'(o_wait_time),   64'd10);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "cnt");
        chk("cnt_wait7", 64'(o_wait_time), 64'd7);
        drain("d1");

        // coin, coin, dispense
        cyc(3'b010, 0, 0, 0, "c500");
        chk("c500_k", 64'(o_input_total), 64'd500);
        cyc(0, 0, 0, 0, "gap");
        cyc(3'b001, 0, 0, 0, "c100");
        chk("c600_k", 64'(o_input_total), 64'd600);
        chk("c600_wait_k", 64'(o_wait_time), 64'd10);
        cyc(0, 0, 0, 0, "gap");
        cyc(0, 0, 4'b0001, 0, "disp400");
        chk("disp_k", 64'(o_input_total), 64'd200);
        chk("disp_wait_k", 64'(o_wait_time), 64'd10);
        drain("d2");

        // credit 1600 return sequence
        cyc(3'b100, 0, 0, 0, "r1");
        cyc(3'b010, 0, 0, 0, "r2");
        cyc(3'b001, 0, 0, 0, "r3");
        chk("r1600_k", 64'(o_input_total), 64'd1600);
        cyc(0, 0, 0, 1, "rtrig");
        cyc(0, 0, 0, 0, "rp1");
        chk("rp1_k", 64'(o_return_coin), 64'(3'b100));
        cyc(0, 0, 0, 0, "rp2");
        chk("rp2_k", 64'(o_return_coin), 64'(3'b010));
        cyc(0, 0, 0, 0, "rp3");
        chk("rp3_k", 64'(o_return_coin), 64'(3'b001));
        cyc(0, 0, 0, 0, "rp4");
        chk("rp4_ret_k", 64'(o_return_coin), 64'd0);
        chk("rp4_rtn_k", 64'(o_returning), 64'd1);
        cyc(0, 0, 0, 0, "rp5");
        chk("rp5_rtn_k", 64'(o_returning), 64'd0);
        chk("rp5_total_k", 64'(o_input_total), 64'd0);

        // timeout path
        cyc(3'b001, 0, 0, 0, "to0");
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "to");
        chk("to_wait_k", 64'(o_wait_time), 64'd0);
        chk("to_rtn_k", 64'(o_returning), 64'd1);
        cyc(0, 0, 0, 0, "to_p");
        chk("to_p_k", 64'(o_return_coin), 64'(3'b001));
        cyc(0, 0, 0, 0, "to_q");
        cyc(0, 0, 0, 0, "to_i");
        chk("to_idle_k", 64'(o_returning), 64'd0);

        // insufficient credit, then coin+dispense netting
        cyc(3'b100, 0, 0, 0, "n1");
        cyc(3'b010, 0, 0, 0, "n2");
        cyc(0, 0, 4'b1000, 0, "nodisp");
        chk("nodisp_k", 64'(o_input_total), 64'd1500);
        cyc(3'b010, 0, 4'b1000, 0, "net");
        chk("net_k", 64'(o_input_total), 64'd0);
        drain("d3");

        // overflow at 2^11-1
        cyc(3'b100, 0, 0, 0, "o1");
        cyc(3'b100, 0, 0, 0, "o2");
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, "o_gap");
        cyc(3'b001, 0, 0, 0, "ovf");
        chk("ovf_k", 64'(o_input_total), 64'd2000);
        chk("ovf_wait_k", 64'(o_wait_time), 64'd10);
        cyc(3'b100, 0, 4'b1000, 0, "ovf_disp");
        chk("ovf_disp_k", 64'(o_input_total), 64'd0);
        drain("d4");

        // async reset mid-payout
        cyc(3'b100, 0, 0, 0, "a1");
        cyc(3'b010, 0, 0, 0, "a2");
        cyc(0, 0, 0, 1, "a_trig");
        cyc(0, 0, 0, 0, "a_p1");
        #2 reset = 1'b1;
        #1;
        chk("ar_total", 64'(o_input_total), 64'd0);
        chk("ar_wait",  64'(o_wait_time),   64'd0);
        chk("ar_ret",   64'(o_return_coin), 64'd0);
        chk("ar_rtn",   64'(o_returning),   64'd0);
        model_reset();
        @(negedge clk) reset = 1'b0;
        cyc(3'b001, 0, 0, 0, "ar_c100");
        chk("ar_c100_k", 64'(o_input_total), 64'd100);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [2:0] c;
            logic [3:0] s, it;
            logic tr;
            c  = ($urandom_range(0, 9) < 3) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
            it = ($urandom_range(0, 9) < 2) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            s  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            tr = ($urandom_range(0, 39) == 0);
            cyc(c, s, it, tr, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
